// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master port bundle used between one master and the on-chip memory arbiter.
//   master modport : the requesting side (CPU data master, frame/sprite engine)
//   slave modport  : the arbiter side
// Signals:
//   address[14:0]    word address
//   byteenable[3:0]  byte lanes
//   read, write      request strobes (write wins when both are high)
//   writedata[31:0]  write data
//   waitrequest      high = request not accepted this cycle
//   readdata[31:0]   read data
//   readdatavalid    one-cycle pulse marking readdata for this master
interface onchip_mem_arbiter_if;
  logic [14:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for one single-port 32-bit on-chip RAM (1-cycle read latency).
// m0 is the CPU data master, m1 the frame/sprite engine. At most one transfer is granted
// per cycle; under contention the current owner keeps the RAM for up to MAX_BURST
// consecutive grants, then ownership flips. Addresses >= DEPTH are accepted but never
// reach the RAM: writes are dropped and reads return zero.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   m0, m1              Avalon-MM slave-side bundles (onchip_mem_arbiter_if.slave)
//   mem_*               RAM drive; mem_readdata valid the cycle after the address
// Optional: define ONCHIP_MEM_ARB_PERF_EN to add conflict_count (cycles with both masters
// requesting, saturating) and starve_max (longest observed wait streak, saturating at 15).
module onchip_mem_arbiter #(
  parameter int unsigned DEPTH     = 32000,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  onchip_mem_arbiter_if.slave        m0,
  onchip_mem_arbiter_if.slave        m1,
  output logic [14:0]                mem_address,
  output logic [3:0]                 mem_byteenable,
  output logic                       mem_chipselect,
  output logic                       mem_write,
  output logic [31:0]                mem_writedata,
  output logic                       mem_clken,
  input  logic [31:0]                mem_readdata
`ifdef ONCHIP_MEM_ARB_PERF_EN
  ,
  output logic [15:0]                conflict_count,
  output logic [3:0]                 starve_max
`endif
);

  localparam logic [15:0] DepthW    = 16'(DEPTH);
  localparam logic [3:0]  MaxBurstW = 4'(MAX_BURST);

  logic        req0, req1, gnt_vld, gnt_id, sel_m1;
  logic        sel_wr, sel_rd, in_range, wait0, wait1;
  logic [14:0] sel_addr;
  logic [31:0] rdata;

  logic        last_q, last_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_owner_q, rd_owner_d;
  logic        rd_oor_q, rd_oor_d;

  // Grant decision and RAM mux
  always_comb begin
    req0    = m0.read | m0.write;
    req1    = m1.read | m1.write;
    gnt_vld = ~reset & (req0 | req1);
    gnt_id  = 1'b0;
    if (req0 && req1) begin
      // Owner keeps the RAM until its run reaches MAX_BURST, then the waiter gets it
      gnt_id = (run_cnt_q < MaxBurstW) ? last_q : ~last_q;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
    // With no grant the mux rests on m0
    sel_m1   = gnt_vld & gnt_id;
    sel_addr = sel_m1 ? m1.address : m0.address;
    sel_wr   = sel_m1 ? m1.write : m0.write;
    sel_rd   = (sel_m1 ? m1.read : m0.read) & ~sel_wr;
    in_range = {1'b0, sel_addr} < DepthW;
    wait0    = ~(gnt_vld & ~gnt_id);
    wait1    = ~(gnt_vld & gnt_id);
    rdata    = rd_oor_q ? 32'h0 : mem_readdata;
  end

  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_m1 ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = sel_m1 ? m1.writedata : m0.writedata;
  assign mem_write      = gnt_vld & sel_wr & in_range;
  assign mem_chipselect = gnt_vld & in_range;
  assign mem_clken      = ~reset;

  assign m0.waitrequest   = wait0;
  assign m1.waitrequest   = wait1;
  assign m0.readdata      = rdata;
  assign m1.readdata      = rdata;
  assign m0.readdatavalid = ~reset & rd_pend_q & ~rd_owner_q;
  assign m1.readdatavalid = ~reset & rd_pend_q & rd_owner_q;

  always_comb begin
    run_cnt_d  = 4'd0;
    last_d     = last_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    rd_oor_d   = rd_oor_q;
    if (gnt_vld) begin
      if (gnt_id == last_q) begin
        run_cnt_d = (run_cnt_q < MaxBurstW) ? run_cnt_q + 4'd1 : MaxBurstW;
      end else begin
        run_cnt_d = 4'd1;
      end
      last_d = gnt_id;
      if (sel_rd) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = gnt_id;
        rd_oor_d   = ~in_range;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= 1'b0;
      run_cnt_q  <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      run_cnt_q  <= run_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

`ifdef ONCHIP_MEM_ARB_PERF_EN
  logic [15:0] conflict_q, conflict_d;
  logic [3:0]  starve_q, starve_d;
  logic [3:0]  wait0_q, wait0_d, wait1_q, wait1_d;

  always_comb begin
    conflict_d = conflict_q;
    if (req0 && req1 && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
    // Per-master current wait streak; a grant or dropped request ends it
    wait0_d = (req0 && wait0) ? ((wait0_q == 4'hF) ? 4'hF : wait0_q + 4'd1) : 4'd0;
    wait1_d = (req1 && wait1) ? ((wait1_q == 4'hF) ? 4'hF : wait1_q + 4'd1) : 4'd0;
    starve_d = starve_q;
    if (wait0_d > starve_d) starve_d = wait0_d;
    if (wait1_d > starve_d) starve_d = wait1_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_q <= 16'd0;
      starve_q   <= 4'd0;
      wait0_q    <= 4'd0;
      wait1_q    <= 4'd0;
    end else begin
      conflict_q <= conflict_d;
      starve_q   <= starve_d;
      wait0_q    <= wait0_d;
      wait1_q    <= wait1_d;
    end
  end

  assign conflict_count = conflict_q;
  assign starve_max     = starve_q;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: instance 0 uses MAX_BURST=4, instance 1 MAX_BURST=1.
// Each instance has a behavioural 1-cycle-latency RAM. Expected read returns are queued
// when a read is expected to be granted and checked by a monitor one cycle later.
module tb_onchip_mem_arbiter;

  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  rd_exp_t     sb [2][$];

  logic [14:0] addr [2][2];
  logic [3:0]  be   [2][2];
  logic        rd   [2][2];
  logic        wr   [2][2];
  logic [31:0] wd   [2][2];
  logic        wreq [2][2];
  logic        rdv  [2][2];
  logic [31:0] rdat [2][2];
  logic [14:0] maddr [2];
  logic [3:0]  mbe   [2];
  logic        mcs   [2];
  logic        mwr   [2];
  logic        mclk  [2];
  logic [31:0] mwd   [2];
`ifdef ONCHIP_MEM_ARB_PERF_EN
  logic [15:0] cc [2];
  logic [3:0]  sm [2];
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    onchip_mem_arbiter_if m0_if ();
    onchip_mem_arbiter_if m1_if ();
    logic [31:0] ram [32768];
    logic [31:0] ram_rd;

    assign m0_if.address    = addr[d][0];
    assign m0_if.byteenable = be[d][0];
    assign m0_if.read       = rd[d][0];
    assign m0_if.write      = wr[d][0];
    assign m0_if.writedata  = wd[d][0];
    assign m1_if.address    = addr[d][1];
    assign m1_if.byteenable = be[d][1];
    assign m1_if.read       = rd[d][1];
    assign m1_if.write      = wr[d][1];
    assign m1_if.writedata  = wd[d][1];
    assign wreq[d][0] = m0_if.waitrequest;
    assign wreq[d][1] = m1_if.waitrequest;
    assign rdv[d][0]  = m0_if.readdatavalid;
    assign rdv[d][1]  = m1_if.readdatavalid;
    assign rdat[d][0] = m0_if.readdata;
    assign rdat[d][1] = m1_if.readdata;

    onchip_mem_arbiter #(
      .DEPTH    (32000),
      .MAX_BURST((d == 0) ? 4 : 1)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .m0            (m0_if),
      .m1            (m1_if),
      .mem_address   (maddr[d]),
      .mem_byteenable(mbe[d]),
      .mem_chipselect(mcs[d]),
      .mem_write     (mwr[d]),
      .mem_writedata (mwd[d]),
      .mem_clken     (mclk[d]),
      .mem_readdata  (ram_rd)
`ifdef ONCHIP_MEM_ARB_PERF_EN
      ,
      .conflict_count(cc[d]),
      .starve_max    (sm[d])
`endif
    );

    always @(posedge clk) begin
      if (mclk[d]) begin
        if (mcs[d] && mwr[d]) begin
          for (int b = 0; b < 4; b++) begin
            if (mbe[d][b]) ram[maddr[d]][8*b +: 8] <= mwd[d][8*b +: 8];
          end
        end
        ram_rd <= ram[maddr[d]];
      end
    end
  end

  // Read-return monitor: pops an expectation in its due cycle, otherwise demands silence
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
          e = sb[d].pop_front();
          if (rdv[d][e.owner] !== 1'b1 || rdv[d][~e.owner] !== 1'b0
              || rdat[d][e.owner] !== e.data) begin
            bad++;
            $display("FAIL rd_return dut%0d: valid m0/m1=%b/%b data=%h, required m%0d valid data=%h",
                     d, rdv[d][0], rdv[d][1], rdat[d][e.owner], e.owner, e.data);
          end
        end else if (rdv[d][0] !== 1'b0 || rdv[d][1] !== 1'b0) begin
          bad++;
          $display("FAIL no_valid dut%0d cyc%0d: valid m0/m1=%b/%b, required 0/0",
                   d, cyc, rdv[d][0], rdv[d][1]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int d, input int m, input logic r, input logic w,
                       input logic [14:0] a, input logic [31:0] data, input logic [3:0] b);
    addr[d][m] = a;
    rd[d][m]   = r;
    wr[d][m]   = w;
    wd[d][m]   = data;
    be[d][m]   = b;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) drive(d, m, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Requests present while reset is held
    drive(0, 0, 1'b1, 1'b0, 15'h10, 32'h0, 4'hF);
    drive(0, 1, 1'b0, 1'b1, 15'h11, 32'h1, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], wreq[0][1], rdv[0][0], rdv[0][1], mcs[0], mwr[0], mclk[0]} !== 7'b1100000) begin
      bad++;
      $display("FAIL reset_outputs: got=%b want=1100000",
               {wreq[0][0], wreq[0][1], rdv[0][0], rdv[0][1], mcs[0], mwr[0], mclk[0]});
    end
    next_cycle();
    idle_all();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({wreq[0][0], wreq[0][1], mcs[0], mwr[0], mclk[0]} !== 5'b11001) begin
      bad++;
      $display("FAIL idle_after_reset: got=%b want=11001",
               {wreq[0][0], wreq[0][1], mcs[0], mwr[0], mclk[0]});
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    drive(0, 0, 1'b0, 1'b1, 15'h0010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], wreq[0][1], mcs[0], mwr[0], maddr[0], mbe[0], mwd[0]}
        !== {4'b0111, 15'h0010, 4'hF, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL m0_write: wait=%b%b cs=%b we=%b a=%h be=%h d=%h, want 0 1 1 1 0010 f deadbeef",
               wreq[0][0], wreq[0][1], mcs[0], mwr[0], maddr[0], mbe[0], mwd[0]);
    end
    next_cycle();
    drive(0, 0, 1'b1, 1'b0, 15'h0010, 32'h0, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], mcs[0], mwr[0]} !== 3'b010) begin
      bad++;
      $display("FAIL m0_read: got=%b want=010", {wreq[0][0], mcs[0], mwr[0]});
    end
    sb[0].push_back('{due: cyc + 1, owner: 1'b0, data: 32'hDEADBEEF});
    next_cycle();
    idle_all();
    drive(0, 1, 1'b0, 1'b1, 15'h0011, 32'hA5A50001, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], wreq[0][1], maddr[0]} !== {2'b10, 15'h0011}) begin
      bad++;
      $display("FAIL m1_write: got wait=%b%b a=%h want 10 0011", wreq[0][0], wreq[0][1], maddr[0]);
    end
    next_cycle();
    // Only the low byte lane is written
    drive(0, 1, 1'b0, 1'b1, 15'h0011, 32'hFFFFFFFF, 4'h1);
    next_cycle();
    idle_all();
    @(negedge clk);
    total++;
    if ({wreq[0][0], wreq[0][1], mcs[0], mwr[0]} !== 4'b1100) begin
      bad++;
      $display("FAIL idle_no_grant: got=%b want=1100", {wreq[0][0], wreq[0][1], mcs[0], mwr[0]});
    end
    next_cycle();
  endtask

  task automatic test_burst();
    logic g;
    pulse_reset();
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1'b1, 1'b0, 15'h0010, 32'h0, 4'hF);
      drive(0, 1, 1'b1, 1'b0, 15'h0011, 32'h0, 4'hF);
      g = ((k / 4) % 2) == 1;
      @(negedge clk);
      total++;
      if ({wreq[0][0], wreq[0][1], mcs[0], maddr[0]} !== {g, ~g, 1'b1, g ? 15'h0011 : 15'h0010}) begin
        bad++;
        $display("FAIL burst_grant k=%0d: wait=%b%b cs=%b a=%h, want grant m%0d",
                 k, wreq[0][0], wreq[0][1], mcs[0], maddr[0], g);
      end
      sb[0].push_back('{due: cyc + 1, owner: g, data: g ? 32'hA5A500FF : 32'hDEADBEEF});
      next_cycle();
    end
    idle_all();
    next_cycle();
  endtask

  task automatic test_alternate();
    logic        g;
    logic [31:0] c0 = 32'd0;
    logic [31:0] c1 = 32'd0;
    for (int k = 0; k < 8; k++) begin
      // Each master advances its data only after being accepted
      drive(1, 0, 1'b0, 1'b1, 15'd1, 32'h100 + c0, 4'hF);
      drive(1, 1, 1'b0, 1'b1, 15'd2, 32'h200 + c1, 4'hF);
      g = (k % 2) == 1;
      @(negedge clk);
      total++;
      if ({wreq[1][0], wreq[1][1], mwr[1], maddr[1], mwd[1]}
          !== {g, ~g, 1'b1, g ? 15'd2 : 15'd1, g ? 32'h200 + c1 : 32'h100 + c0}) begin
        bad++;
        $display("FAIL alt_grant k=%0d: wait=%b%b we=%b a=%h d=%h, want grant m%0d",
                 k, wreq[1][0], wreq[1][1], mwr[1], maddr[1], mwd[1], g);
      end
      if (g) c1 = c1 + 32'd1;
      else   c0 = c0 + 32'd1;
      next_cycle();
    end
    idle_all();
    next_cycle();
    total++;
    if (g_dut[1].ram[1] !== 32'h100 + c0 - 32'd1 || g_dut[1].ram[2] !== 32'h200 + c1 - 32'd1) begin
      bad++;
      $display("FAIL alt_ram: got %h/%h want %h/%h", g_dut[1].ram[1], g_dut[1].ram[2],
               32'h100 + c0 - 32'd1, 32'h200 + c1 - 32'd1);
    end
  endtask

  task automatic test_oor();
    drive(0, 1, 1'b0, 1'b1, 15'd32000, 32'h12345678, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][1], mcs[0], mwr[0]} !== 3'b000) begin
      bad++;
      $display("FAIL oor_write: got=%b want=000", {wreq[0][1], mcs[0], mwr[0]});
    end
    next_cycle();
    drive(0, 1, 1'b1, 1'b0, 15'd32000, 32'h0, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][1], mcs[0]} !== 2'b00) begin
      bad++;
      $display("FAIL oor_read: got=%b want=00", {wreq[0][1], mcs[0]});
    end
    sb[0].push_back('{due: cyc + 1, owner: 1'b1, data: 32'h0});
    next_cycle();
    idle_all();
    drive(0, 0, 1'b0, 1'b1, 15'd31999, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], mcs[0], mwr[0]} !== 3'b011) begin
      bad++;
      $display("FAIL last_word_write: got=%b want=011", {wreq[0][0], mcs[0], mwr[0]});
    end
    next_cycle();
    drive(0, 0, 1'b1, 1'b0, 15'd31999, 32'h0, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], mcs[0]} !== 2'b01) begin
      bad++;
      $display("FAIL last_word_read: got=%b want=01", {wreq[0][0], mcs[0]});
    end
    sb[0].push_back('{due: cyc + 1, owner: 1'b0, data: 32'h0BADF00D});
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    // Hand ownership to m1, then reset must restore m0 as the contention winner
    drive(0, 1, 1'b0, 1'b1, 15'h21, 32'h2, 4'hF);
    @(negedge clk);
    total++;
    if (wreq[0][1] !== 1'b0) begin
      bad++;
      $display("FAIL m1_alone: wait=%b want 0", wreq[0][1]);
    end
    next_cycle();
    pulse_reset();
    drive(0, 0, 1'b0, 1'b1, 15'h20, 32'h1, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], wreq[0][1]} !== 2'b01) begin
      bad++;
      $display("FAIL first_contention: wait=%b%b want 01", wreq[0][0], wreq[0][1]);
    end
    next_cycle();
    idle_all();
    drive(0, 0, 1'b1, 1'b0, 15'h10, 32'h0, 4'hF);
    @(negedge clk);
    total++;
    if (wreq[0][0] !== 1'b0) begin
      bad++;
      $display("FAIL inflight_grant: wait=%b want 0", wreq[0][0]);
    end
    next_cycle();
    idle_all();
    pulse_reset();
    @(negedge clk);
    total++;
    if ({rdv[0][0], rdv[0][1]} !== 2'b00) begin
      bad++;
      $display("FAIL dropped_read: valid=%b%b want 00", rdv[0][0], rdv[0][1]);
    end
    next_cycle();
    drive(0, 0, 1'b0, 1'b1, 15'h20, 32'h1, 4'hF);
    drive(0, 1, 1'b0, 1'b1, 15'h21, 32'h2, 4'hF);
    @(negedge clk);
    total++;
    if ({wreq[0][0], wreq[0][1]} !== 2'b01) begin
      bad++;
      $display("FAIL contention_after_drop: wait=%b%b want 01", wreq[0][0], wreq[0][1]);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

`ifdef ONCHIP_MEM_ARB_PERF_EN
  task automatic test_perf();
    pulse_reset();
    @(negedge clk);
    total++;
    if (cc[0] !== 16'd0 || sm[0] !== 4'd0) begin
      bad++;
      $display("FAIL perf_reset: cc=%0d sm=%0d want 0 0", cc[0], sm[0]);
    end
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1'b0, 1'b1, 15'h40, 32'h40, 4'hF);
      drive(0, 1, 1'b0, 1'b1, 15'h41, 32'h41, 4'hF);
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    total++;
    if (cc[0] !== 16'd10 || sm[0] !== 4'd4) begin
      bad++;
      $display("FAIL perf_counts: cc=%0d sm=%0d want 10 4", cc[0], sm[0]);
    end
    next_cycle();
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_burst();
    test_alternate();
    test_oor();
    test_reset_inflight();
`ifdef ONCHIP_MEM_ARB_PERF_EN
    test_perf();
`endif
    repeat (2) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-port arbiter sharing one single-port 32-bit on-chip RAM (15-bit word address, 4-bit byte enable, 1-cycle read latency) between two Avalon-MM masters.
- m0 is the Nios CPU data master. m1 is the pong frame/sprite engine.
- Grants at most one transfer per cycle, with bounded-burst round-robin.
- Returns read data to the owning master with readdatavalid.

Parameters:
- DEPTH, 32000: implemented words; addresses >= DEPTH are out of range.
- MAX_BURST, 4: max consecutive grants to one master while the other is waiting (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address, m1_address  in  15  word address
- m0_byteenable, m1_byteenable  in  4  byte lanes
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_writedata, m1_writedata  in  32  write data
- m0_waitrequest, m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata, m1_readdata  out  32  read data
- m0_readdatavalid, m1_readdatavalid  out  1  read data valid, one cycle pulse
- mem_address  out  15  to RAM
- mem_byteenable  out  4  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  32  to RAM
- mem_clken  out  1  to RAM
- mem_readdata  in  32  from RAM, valid the cycle after address

Behaviour:
- reqN = mN_read | mN_write. If a master asserts both read and write, write wins; the read is ignored.
- Registered state:
  - last: master most recently granted; reset 0.
  - run_cnt: 4 bits; reset 0.
  - rd_pend: 1 bit; reset 0.
  - rd_owner: 1 bit; reset 0.
  - rd_oor: 1 bit; reset 0.
- Grant (combinational, same cycle):
  - Only one requester: grant it.
  - Both requesting and run_cnt < MAX_BURST: grant last.
  - Both requesting and run_cnt == MAX_BURST: grant ~last.
  - Neither requesting: no grant.
- Granted master sees waitrequest=0 in the same cycle. A requesting master that is not granted sees waitrequest=1. A non-requesting master sees waitrequest=1.
- Update at clock edge:
  - On grant g: if g==last, run_cnt = min(run_cnt+1, MAX_BURST); otherwise run_cnt = 1. Then last = g.
  - No grant: run_cnt = 0; last unchanged.
- RAM drive:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master. With no grant they come from m0.
  - mem_write = granted write AND address < DEPTH.
  - mem_chipselect = grant present AND address < DEPTH.
  - mem_clken = ~reset.
- Read return, 1-cycle latency:
  - A granted read sets rd_pend=1, rd_owner=g, rd_oor=(address >= DEPTH) at the edge. Otherwise rd_pend=0.
  - Cycle after grant: mN_readdatavalid = rd_pend & (rd_owner==N).
  - Both mN_readdata = rd_oor ? 0 : mem_readdata.
  - Back-to-back reads from alternating masters each get exactly one valid pulse, in grant order.
- Out-of-range (address 32000..32767):
  - Writes are accepted (waitrequest=0) and discarded.
  - Reads are accepted and return 0x00000000 with readdatavalid.
- Reset asserted (async):
  - Both waitrequest=1, both readdatavalid=0, mem_write=0, mem_chipselect=0.
  - All state clears immediately.
  - A read in flight at reset is dropped; no valid pulse after deassertion.
- Simultaneous first contention after idle: last wins. After reset this is m0.
- MAX_BURST=1 with continuous contention: strict alternation.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_PERF_EN.
- Defined:
  - Adds output ports conflict_count (16 bits) and starve_max (4 bits), both reset 0.
  - conflict_count increments (saturating at 0xFFFF) every cycle both masters request.
  - starve_max holds the largest number of consecutive cycles any master waited with req high and waitrequest=1, saturating at 15.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then m0 write 0xDEADBEEF to addr 0x0010 with byteenable 0xF, then m0 read 0x0010 → waitrequest=0 on both requests; m0_readdatavalid is high exactly one cycle after the read grant with readdata 0xDEADBEEF; m1_readdatavalid stays 0.
- MAX_BURST=4, both masters issue continuous reads from cycle 0 → grants follow m0 x4, m1 x4, m0 x4…; each readdatavalid pulse is on the owning master, one cycle after its grant.
- MAX_BURST=1, both masters write continuously (m0 to addr 1, m1 to addr 2) → grants alternate m0, m1, m0…; final RAM contents hold both masters' last data.
- m1 writes 0x12345678 to addr 32000, then reads addr 32000 → mem_chipselect=0 on both cycles; m1_readdata is 0x00000000 with m1_readdatavalid=1.
- m0 read granted in cycle N, reset pulsed in cycle N+1 → no readdatavalid after reset deassertion; the first contention afterwards grants m0.
- With ONCHIP_MEM_ARB_PERF_EN and MAX_BURST=4, 10 cycles of continuous contention → conflict_count=10, starve_max=4.
